// File: rtl/hdc_pkg.sv
// Shared types and constants for the sparse HDC classifier control path.
package hdc_pkg;

  localparam int NUM_CLASSES     = 26;
  localparam int LABEL_W         = $clog2(NUM_CLASSES);
  // Minimum cycles one sample spends in the test sequencer with single-cycle responders.
  localparam int SEQ_CYCLE_COUNT = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENC_REQ  = 3'd1,
    S_ENC_WAIT = 3'd2,
    S_AM_REQ   = 3'd3,
    S_AM_WAIT  = 3'd4,
    S_TALLY    = 3'd5,
    S_DONE     = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/hdc_watchdog.sv
// Response watchdog: counts enabled cycles since the last clear and flags the final allowed cycle.
module hdc_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] count_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (cnt_en) begin
      count_reg <= count_reg + WD_W'(1);
    end
  end

  // Expiry is only meaningful in a cycle the owner is actually counting.
  assign expired = cnt_en && (count_reg == WD_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hdc_test_ctrl.sv
// Test-phase sequencer: walks the dataset, drives encoder and AM requests, and tallies correct predictions.
module hdc_test_ctrl #(
  parameter  int NUM_SAMPLES    = 1000,
  parameter  int NUM_CLASSES    = 26,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int LABEL_W        = $clog2(NUM_CLASSES),
  localparam int IDX_W          = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int CNT_W          = $clog2(NUM_SAMPLES + 1)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               start,
  input  logic               abort,
  output logic               enc_start,
  input  logic               enc_done,
  input  logic [LABEL_W-1:0] true_label,
  output logic               am_start,
  output logic               am_last,
  input  logic               am_result_valid,
  input  logic [LABEL_W-1:0] am_pred_class,
  output logic [IDX_W-1:0]   sample_idx,
  output logic [CNT_W-1:0]   correct_count,
  output logic               busy,
  output logic               done,
  output logic               error
);

  import hdc_pkg::*;

  ctrl_state_t          state_reg;
  logic [IDX_W-1:0]     sample_idx_reg;
  logic [CNT_W-1:0]     correct_count_reg;
  logic                 error_reg;
  logic [LABEL_W-1:0]   label_reg;
  logic [LABEL_W-1:0]   pred_reg;

  logic in_wait;
  logic last_sample;
  logic wd_expired;

  assign in_wait     = (state_reg == S_ENC_WAIT) || (state_reg == S_AM_WAIT);
  assign last_sample = (sample_idx_reg == IDX_W'(NUM_SAMPLES - 1));

  // Holding clear outside the WAIT states gives a fresh count on every WAIT entry.
  hdc_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (!in_wait),
    .cnt_en  (en && in_wait),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg         <= S_IDLE;
      sample_idx_reg    <= '0;
      correct_count_reg <= '0;
      error_reg         <= 1'b0;
      label_reg         <= '0;
      pred_reg          <= '0;
    end else if (abort) begin
      state_reg <= S_IDLE;
    end else if (en) begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sample_idx_reg    <= '0;
            correct_count_reg <= '0;
            error_reg         <= 1'b0;
            state_reg         <= S_ENC_REQ;
          end
        end
        S_ENC_REQ: state_reg <= S_ENC_WAIT;
        S_ENC_WAIT: begin
          // A response in the expiry cycle still counts as on time.
          if (enc_done) begin
            label_reg <= true_label;
            state_reg <= S_AM_REQ;
          end else if (wd_expired) begin
            error_reg <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        S_AM_REQ: state_reg <= S_AM_WAIT;
        S_AM_WAIT: begin
          if (am_result_valid) begin
            pred_reg  <= am_pred_class;
            state_reg <= S_TALLY;
          end else if (wd_expired) begin
            error_reg <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        S_TALLY: begin
          if (pred_reg == label_reg) begin
            correct_count_reg <= correct_count_reg + CNT_W'(1);
          end
          if (last_sample) begin
            state_reg <= S_DONE;
          end else begin
            sample_idx_reg <= sample_idx_reg + IDX_W'(1);
            state_reg      <= S_ENC_REQ;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign enc_start     = en && (state_reg == S_ENC_REQ);
  assign am_start      = en && (state_reg == S_AM_REQ);
  assign am_last       = am_start && last_sample;
  assign done          = en && (state_reg == S_DONE);
  assign busy          = (state_reg != S_IDLE);
  assign error         = error_reg;
  assign sample_idx    = sample_idx_reg;
  assign correct_count = correct_count_reg;

endmodule

// File: doc/hdc_test_ctrl.md
# hdc_test_ctrl

Top-level test-phase sequencer for the sparse HDC classifier. For each test sample it walks the index through the dataset: it requests query-HV encoding, launches the associative-memory query, compares the predicted class against the true label and tallies accuracy. It sits above the encoder and the associative-memory FSM, and reports run completion, accuracy count and watchdog errors to the host/CSR layer.

## Interface
- NUM_SAMPLES, 1000 — test samples per run (≥1)
- NUM_CLASSES, 26 — class count; LABEL_W = $clog2(NUM_CLASSES) = 5
- TIMEOUT_CYCLES, 1024 — max cycles waiting for encoder/AM response (≥2)
- IDX_W = $clog2(NUM_SAMPLES), CNT_W = $clog2(NUM_SAMPLES+1) — derived localparams
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- en  in  1  global enable; low freezes FSM, counters and watchdog
- start  in  1  begin run; accepted only in S_IDLE
- abort  in  1  synchronous abort, highest priority
- enc_start  out  1  one-cycle request to encode sample sample_idx
- enc_done  in  1  encoder pulse: query HV ready, true_label valid this cycle
- true_label  in  LABEL_W  label of current sample, sampled on enc_done
- am_start  out  1  one-cycle request to query associative memory
- am_last  out  1  qualifies am_start: current sample is the final one
- am_result_valid  in  1  AM pulse: am_pred_class valid
- am_pred_class  in  LABEL_W  inferred class
- sample_idx  out  IDX_W  current sample index
- correct_count  out  CNT_W  correctly classified samples this run
- busy  out  1  high in every state except S_IDLE
- done  out  1  one-cycle pulse on normal run completion
- error  out  1  sticky watchdog timeout flag; cleared by accepted start

## Operation
- States (hdc_pkg::ctrl_state_t): S_IDLE, S_ENC_REQ, S_ENC_WAIT, S_AM_REQ, S_AM_WAIT, S_TALLY, S_DONE.
- S_IDLE: start && en && !abort → sample_idx←0, correct_count←0, error←0, go S_ENC_REQ.
- S_ENC_REQ: enc_start = en; → S_ENC_WAIT when en.
- S_ENC_WAIT: on enc_done, latch true_label → S_AM_REQ.
- S_AM_REQ: am_start = en; am_last = (sample_idx == NUM_SAMPLES-1); → S_AM_WAIT when en.
- S_AM_WAIT: on am_result_valid, latch am_pred_class → S_TALLY.
- S_TALLY: if pred == label, correct_count +1. Cannot overflow, because CNT_W covers NUM_SAMPLES. If last sample → S_DONE, else sample_idx +1 → S_ENC_REQ.
- S_DONE: done=1 → S_IDLE. sample_idx and correct_count hold until the next accepted start.
- Watchdog: counter cleared on entry to each WAIT state, increments per en cycle. At TIMEOUT_CYCLES-1 with no response: error←1 → S_IDLE, no done.
- abort (any state, en-independent) → S_IDLE next cycle. No done, error unchanged, counters hold.
- en low: state, counters and watchdog hold. enc_start/am_start are forced low.
- Ignored inputs: start when busy; enc_done outside S_ENC_WAIT; am_result_valid outside S_AM_WAIT.
- Simultaneous events: a response arriving in the timeout cycle wins (no error). abort beats start and beats any response.

## Timing
- Reset: state S_IDLE. All outputs 0: sample_idx, correct_count, busy, done, error, enc_start, am_start, am_last.
- Outputs are Moore, decoded from registered state, qualified by en only.
- start sampled at edge 0 → enc_start high cycle 1.
- Per-sample minimum is 5 cycles (single-cycle encoder/AM responses).
- done is high the cycle after the last S_TALLY; busy drops the cycle after that.
- correct_count updates at the edge leaving S_TALLY.

## Structure
- hdc_pkg: ctrl_state_t enum, NUM_CLASSES, LABEL_W, SEQ_CYCLE_COUNT shared with the AM FSM.
- Sub-module hdc_watchdog (clear, count-enable, TIMEOUT_CYCLES parameter, expired output).
- Everything else lives in hdc_test_ctrl.

## Test plan
- NUM_SAMPLES=4, responses 1 cycle after each request, pred==label for all → done after 20 cycles, correct_count=4, sample_idx=3, error=0.
- NUM_SAMPLES=4, mismatch on samples 1 and 3 → correct_count=2. am_last high only with the 4th am_start.
- TIMEOUT_CYCLES=8, encoder silent → error=1 and busy=0 eight cycles after entering S_ENC_WAIT; no done. Next start clears error.
- abort asserted in S_AM_WAIT with am_result_valid the same cycle → S_IDLE, correct_count unchanged, no done.
- en low for 5 cycles during S_ENC_REQ → enc_start stays low, then a single pulse once en rises. start while busy ignored.
- nrst asserted mid-run → all outputs 0 immediately. Subsequent start runs cleanly from sample 0.
